// File: rtl/instr_fetch.sv
// instr_fetch: fetch PC owner, drives the combinational instruction ROM and
// buffers {pc, instr} pairs in a DEPTH-entry prefetch queue handed to decode
// over valid/ready. A redirect flushes the queue and restarts at redirect_pc.
// Optional macro FETCH_PERF_EN adds saturating fetch_count / stall_count ports.

module instr_fetch #(
  parameter int unsigned               ADDRESS_WIDTH = 32,
  parameter int unsigned               DATA_WIDTH    = 32,
  parameter int unsigned               DEPTH         = 4,
  parameter logic [ADDRESS_WIDTH-1:0]  RESET_PC      = '0,
  parameter int unsigned               PC_STEP       = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic [ADDRESS_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0]    rom_instr,
  input  logic                     redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_instr,
  output logic [ADDRESS_WIDTH-1:0] out_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]              fetch_count,
  output logic [31:0]              stall_count
`endif
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [ADDRESS_WIDTH-1:0] r_fetch_pc;
  logic [PTR_W-1:0]         r_wr_ptr;
  logic [PTR_W-1:0]         r_rd_ptr;
  logic [CNT_W-1:0]         r_count;
  logic [ADDRESS_WIDTH-1:0] r_mem_pc    [DEPTH];
  logic [DATA_WIDTH-1:0]    r_mem_instr [DEPTH];

  logic                     w_pop;
  logic                     w_push;
  logic                     w_full;
  logic                     w_nonempty;
  logic [CNT_W-1:0]         w_count_nxt;

  assign rom_addr = r_fetch_pc;

  // Handshake, push decision, occupancy update and head presentation
  always_comb begin
    w_full      = (r_count == CNT_W'(DEPTH));
    w_nonempty  = (r_count != '0);
    out_valid   = w_nonempty & ~redirect_valid;
    out_pc      = '0;
    out_instr   = '0;
    w_pop       = out_valid & out_ready;
    w_push      = ~redirect_valid & (~w_full | w_pop);
    w_count_nxt = r_count;
    if (w_nonempty) begin
      out_pc    = r_mem_pc[r_rd_ptr];
      out_instr = r_mem_instr[r_rd_ptr];
    end
    if (redirect_valid) begin
      w_count_nxt = '0;
    end else begin
      unique case ({w_push, w_pop})
        2'b10:   w_count_nxt = r_count + CNT_W'(1);
        2'b01:   w_count_nxt = r_count - CNT_W'(1);
        default: w_count_nxt = r_count;
      endcase
    end
  end

  // Fetch PC, queue pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else begin
      r_count <= w_count_nxt;
      if (redirect_valid) begin
        r_fetch_pc <= redirect_pc;
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
      end else begin
        if (w_push) begin
          r_fetch_pc <= r_fetch_pc + ADDRESS_WIDTH'(PC_STEP);
          r_wr_ptr   <= r_wr_ptr + PTR_W'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
      end
    end
  end

  // Queue storage; contents are qualified by r_count so no reset is needed
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_pc[r_wr_ptr]    <= r_fetch_pc;
      r_mem_instr[r_wr_ptr] <= rom_instr;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] r_fetch_count;
  logic [31:0] r_stall_count;
  logic        w_stall;

  assign w_stall     = w_full & ~w_pop & ~redirect_valid;
  assign fetch_count = r_fetch_count;
  assign stall_count = r_stall_count;

  // Saturating counters: instructions handed to decode, cycles blocked by full queue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_count <= '0;
      r_stall_count <= '0;
    end else begin
      if (w_pop && (r_fetch_count != 32'hFFFF_FFFF)) begin
        r_fetch_count <= r_fetch_count + 32'd1;
      end
      if (w_stall && (r_stall_count != 32'hFFFF_FFFF)) begin
        r_stall_count <= r_stall_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: ROM word at address A is A>>2. Expected pops are
// queued by the stimulus process; a negedge monitor pops and compares.
module tb_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic [31:0] rom_addr;
  logic [31:0] rom_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  instr_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rom_addr       (rom_addr),
    .rom_instr      (rom_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
`ifdef FETCH_PERF_EN
    ,
    .fetch_count    (fetch_count),
    .stall_count    (stall_count)
`endif
  );

  assign rom_instr = {2'b00, rom_addr[31:2]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_pop(input logic [31:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = {2'b00, pc[31:2]};
    exp_q.push_back(e);
  endtask

  // Monitor: every accepted head must match the next expected entry
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pop: got pc %h instr %h expected no transfer", out_pc, out_instr);
      end else begin
        mon_e = exp_q.pop_front();
        if (out_pc !== mon_e.pc || out_instr !== mon_e.instr) begin
          n_fail++;
          $display("FAIL pop: got pc %h instr %h expected pc %h instr %h",
                   out_pc, out_instr, mon_e.pc, mon_e.instr);
        end
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected end of stimulus");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b0;
    #2;
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_pc", out_pc, 32'h0);
    check("reset_instr", out_instr, 32'h0);
    check("reset_rom_addr", rom_addr, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check("first_cycle_valid", 32'(out_valid), 32'd0);

    // Fill with out_ready low for 10 cycles
    repeat (10) tick();
    check("full_rom_addr", rom_addr, 32'h10);
    check("full_valid", 32'(out_valid), 32'd1);
    check("full_head_pc", out_pc, 32'h0);
    check("full_head_instr", out_instr, 32'h0);
`ifdef FETCH_PERF_EN
    check("stall_count_full", stall_count, 32'd6);
    check("fetch_count_full", fetch_count, 32'd0);
`endif

    // One-cycle pop while full: push and pop together
    expect_pop(32'h0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("pulse_rom_addr", rom_addr, 32'h14);
    check("pulse_head_pc", out_pc, 32'h4);
    check("pulse_head_instr", out_instr, 32'h1);
`ifdef FETCH_PERF_EN
    check("fetch_count_pulse", fetch_count, 32'd1);
    check("stall_count_pulse", stall_count, 32'd6);
`endif

    // Flush a full queue, then queue 3 entries from 0x200
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    #1;
    check("redirect_forces_invalid", 32'(out_valid), 32'd0);
    tick();
    redirect_valid = 1'b0;
    #1;
    check("post_flush_valid", 32'(out_valid), 32'd0);
    check("post_flush_rom_addr", rom_addr, 32'h200);
    repeat (3) tick();
    check("three_rom_addr", rom_addr, 32'h20C);
    check("three_head_pc", out_pc, 32'h200);
    check("three_head_instr", out_instr, 32'h80);

    // Redirect to 0x100 held two cycles with 3 entries queued
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    out_ready      = 1'b1;
    #1;
    check("redir3_valid", 32'(out_valid), 32'd0);
    tick();
    check("redir_hold_valid", 32'(out_valid), 32'd0);
    check("redir_hold_rom_addr", rom_addr, 32'h100);
    tick();
    redirect_valid = 1'b0;
    #1;
    check("redir_drop_valid", 32'(out_valid), 32'd0);
    check("redir_drop_rom_addr", rom_addr, 32'h100);
    expect_pop(32'h100);
    expect_pop(32'h104);
    expect_pop(32'h108);
    tick();
    check("redir_first_valid", 32'(out_valid), 32'd1);
    check("redir_first_pc", out_pc, 32'h100);
    repeat (3) tick();
    out_ready = 1'b0;
    check("stream_rom_addr", rom_addr, 32'h110);
    check("stream_head_pc", out_pc, 32'h10C);
`ifdef FETCH_PERF_EN
    check("fetch_count_stream", fetch_count, 32'd4);
    check("stall_count_stream", stall_count, 32'd6);
`endif

    // PC wrap from 0xFFFF_FFFC
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    out_ready      = 1'b1;
    tick();
    redirect_valid = 1'b0;
    expect_pop(32'hFFFF_FFFC);
    expect_pop(32'h0);
    expect_pop(32'h4);
    tick();
    check("wrap_rom_addr", rom_addr, 32'h0);
    check("wrap_head_pc", out_pc, 32'hFFFF_FFFC);
    repeat (3) tick();
    out_ready = 1'b0;
    check("wrap_left_valid", 32'(out_valid), 32'd1);

    // Asynchronous reset mid-stream
    #1;
    rst_n = 1'b0;
    #1;
    check("async_valid", 32'(out_valid), 32'd0);
    check("async_pc", out_pc, 32'h0);
    check("async_instr", out_instr, 32'h0);
    check("async_rom_addr", rom_addr, 32'h0);
`ifdef FETCH_PERF_EN
    check("async_fetch_count", fetch_count, 32'd0);
    check("async_stall_count", stall_count, 32'd0);
`endif

    // Full-rate streaming from reset with out_ready high
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) expect_pop(32'(4 * i));
    rst_n = 1'b1;
    #1;
    check("stream_first_cycle_valid", 32'(out_valid), 32'd0);
    tick();
    check("stream_valid", 32'(out_valid), 32'd1);
    check("stream_pc0", out_pc, 32'h0);
    repeat (8) tick();
    out_ready = 1'b0;
    check("stream_end_rom_addr", rom_addr, 32'h24);
`ifdef FETCH_PERF_EN
    check("stream_fetch_count", fetch_count, 32'd8);
`endif
    repeat (2) tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch front end for the single-cycle/pipelined RISC-V core. Owns the fetch program counter, drives the address into the combinational instruction ROM, captures each returned instruction with its PC into a small prefetch queue, and presents them in order to decode over a valid/ready handshake. Branch/jump redirects flush the queue and restart fetch at the target.

## Interface
- ADDRESS_WIDTH, 32, width of PC and ROM address
- DATA_WIDTH, 32, instruction width
- DEPTH, 4, prefetch queue entries; power of two, ≥ 2
- RESET_PC, 0, fetch PC after reset
- PC_STEP, 4, PC increment per fetched instruction
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- rom_addr  output  ADDRESS_WIDTH  address to instruction ROM; equals fetch PC register
- rom_instr  input  DATA_WIDTH  ROM read data; combinational from rom_addr, same cycle
- redirect_valid  input  1  flush and restart fetch at redirect_pc
- redirect_pc  input  ADDRESS_WIDTH  redirect target
- out_valid  output  1  queue head valid
- out_ready  input  1  decode accepts head
- out_instr  output  DATA_WIDTH  head instruction
- out_pc  output  ADDRESS_WIDTH  PC of head instruction
- fetch_count  output  32  (FETCH_PERF_EN only) instructions handed to decode
- stall_count  output  32  (FETCH_PERF_EN only) cycles fetch blocked by full queue

## Operation
- State: fetch_pc, DEPTH-entry storage of {pc, instr}, read/write pointers (log2 DEPTH bits, wrap modulo DEPTH), count (0..DEPTH).
- rom_addr = fetch_pc, combinational from the register.
- pop = out_valid & out_ready.
- push = !redirect_valid & (count < DEPTH | pop). Push writes {fetch_pc, rom_instr} at write pointer; fetch_pc ← fetch_pc + PC_STEP, modulo 2^ADDRESS_WIDTH.
- Full with simultaneous pop: push and pop both occur, count unchanged.
- Empty: no pop possible; push alone, count +1.
- Redirect cycle: out_valid forced 0 (no pop), no push, count ← 0, pointers ← 0, fetch_pc ← redirect_pc. Redirect held multiple cycles re-applies each cycle; fetch resumes the cycle after it drops.
- out_valid = (count != 0) & !redirect_valid. out_instr/out_pc = head entry when count != 0, else 0.
- Head must remain stable while out_valid & !out_ready (standard valid/ready: no retraction except by redirect or reset).
- Reset (asserted at any time, mid-operation included): fetch_pc ← RESET_PC, count ← 0, pointers ← 0, counters ← 0; outputs immediately: out_valid 0, out_instr 0, out_pc 0, rom_addr RESET_PC. Queue storage contents need not be reset.

## Timing
- ROM read is zero-latency; instruction captured at the edge ending the cycle fetch_pc is presented.
- Fetch-to-decode latency: 1 cycle. First cycle after rst_n release pushes RESET_PC; out_valid high the following cycle with out_pc = RESET_PC.
- Redirect-to-first-valid: redirect at cycle N, target pushed in N+1, out_valid with out_pc = target in N+2.
- Sustained throughput 1 instruction/cycle with out_ready held high.
- Queue fills to DEPTH after DEPTH cycles of out_ready low from empty; fetch_pc then holds.

## Configuration
- FETCH_PERF_EN defined: fetch_count and stall_count ports exist. fetch_count +1 on every pop; stall_count +1 every cycle with count == DEPTH & !pop & !redirect_valid; both saturate at 32'hFFFF_FFFF; both reset to 0.
- FETCH_PERF_EN undefined: both ports and counters absent; all other behaviour identical.

## Test plan
- Reset release, out_ready = 1, ROM word[i] = i: out_valid first high cycle 2 with out_pc 0, then out_pc 4, 8, 12… one per cycle, out_instr matching ROM.
- out_ready = 0 for 10 cycles from reset: count reaches 4, rom_addr holds 16, stall_count = 6 (FETCH_PERF_EN); out_pc stays 0.
- Full queue, out_ready pulsed 1 for one cycle: head PC 0 popped, PC 16 pushed same cycle, count stays 4, rom_addr → 20.
- Redirect to 0x100 with 3 entries queued: out_valid 0 that cycle, next cycle out_valid 0, following cycle out_pc 0x100, then 0x104; old entries never appear.
- rst_n asserted asynchronously mid-stream: out_valid, out_pc, out_instr 0 immediately; rom_addr = RESET_PC; fetch_count 0.
- redirect_pc = 0xFFFF_FFFC: out_pc sequence 0xFFFF_FFFC then 0x0000_0000 (wrap).
